// File: rtl/light_cycle_engine_pkg.sv
// Shared definitions for the light cycle engine: grid geometry, heading/winner codes,
// FSM states and the cell-index helper used by the trace bitmaps.
package light_cycle_engine_pkg;

  localparam int GRID_W = 32;
  localparam int GRID_H = 24;
  localparam int CELLS  = GRID_W * GRID_H;
  localparam int X_W    = 5;
  localparam int Y_W    = 5;
  localparam int IDX_W  = 10;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } state_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  function automatic logic [IDX_W-1:0] cell_idx(input logic [X_W-1:0] x,
                                                input logic [Y_W-1:0] y);
    return IDX_W'(y) * IDX_W'(GRID_W) + IDX_W'(x);
  endfunction

  // Opposite headings differ only in the upper code bit.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

endpackage

// File: rtl/light_cycle_engine_if.sv
// Game-control and trail-bitmap bundle between the engine and its host/scan-out logic.
interface light_cycle_engine_if;

  logic                                   start;
  logic                                   game_tick;
  logic [3:0]                             p1_btn;
  logic [3:0]                             p2_btn;
  logic [light_cycle_engine_pkg::CELLS-1:0] trace_1;
  logic [light_cycle_engine_pkg::CELLS-1:0] trace_2;
  logic                                   running;
  logic                                   game_over;
  logic [1:0]                             winner;

  modport master (
    output start, game_tick, p1_btn, p2_btn,
    input  trace_1, trace_2, running, game_over, winner
  );

  modport slave (
    input  start, game_tick, p1_btn, p2_btn,
    output trace_1, trace_2, running, game_over, winner
  );

endinterface

// File: rtl/light_cycle_engine_player.sv
// One cycle's steering and head position: button decode, reversal filter, pending and
// current heading, head registers and the candidate next head with its off-grid flag.
module light_cycle_engine_player
  import light_cycle_engine_pkg::*;
#(
  parameter logic [X_W-1:0] X0   = 5'd4,
  parameter logic [Y_W-1:0] Y0   = 5'd12,
  parameter dir_t           DIR0 = DIR_RIGHT
) (
  input  logic           dclk,
  input  logic           rst,
  input  logic           load,
  input  logic           run,
  input  logic           step,
  input  logic [3:0]     btn,
  output logic [X_W:0]   next_x,
  output logic [Y_W:0]   next_y,
  output logic           off_grid
);

  logic [X_W-1:0] head_x;
  logic [Y_W-1:0] head_y;
  dir_t           dir;
  dir_t           pending;
  dir_t           req;
  logic           req_valid;

  always_comb begin
    req       = DIR_UP;
    req_valid = 1'b1;
    if (btn[3])      req = DIR_UP;
    else if (btn[2]) req = DIR_RIGHT;
    else if (btn[1]) req = DIR_DOWN;
    else if (btn[0]) req = DIR_LEFT;
    else             req_valid = 1'b0;
  end

  // One extra bit lets x-1 at column 0 wrap to a large value that fails the bound check.
  always_comb begin
    next_x = {1'b0, head_x};
    next_y = {1'b0, head_y};
    case (pending)
      DIR_UP:    next_y = {1'b0, head_y} - (Y_W+1)'(1);
      DIR_RIGHT: next_x = {1'b0, head_x} + (X_W+1)'(1);
      DIR_DOWN:  next_y = {1'b0, head_y} + (Y_W+1)'(1);
      DIR_LEFT:  next_x = {1'b0, head_x} - (X_W+1)'(1);
      default:   next_x = {1'b0, head_x};
    endcase
    off_grid = (next_x >= (X_W+1)'(GRID_W)) || (next_y >= (Y_W+1)'(GRID_H));
  end

  always_ff @(posedge dclk) begin
    if (rst || load) begin
      head_x  <= X0;
      head_y  <= Y0;
      dir     <= DIR0;
      pending <= DIR0;
    end else begin
      if (step) begin
        dir    <= pending;
        head_x <= next_x[X_W-1:0];
        head_y <= next_y[Y_W-1:0];
      end
      if (run && req_valid && (req != opposite(dir))) begin
        pending <= req;
      end
    end
  end

endmodule

// File: rtl/light_cycle_engine.sv
// Light Cycles game-state core: round FSM, both trail bitmaps, crash detection and
// winner declaration on a 32x24 grid.
module light_cycle_engine
  import light_cycle_engine_pkg::*;
#(
  parameter logic [X_W-1:0] P1_X0   = 5'd4,
  parameter logic [Y_W-1:0] P1_Y0   = 5'd12,
  parameter dir_t           P1_DIR0 = DIR_RIGHT,
  parameter logic [X_W-1:0] P2_X0   = 5'd27,
  parameter logic [Y_W-1:0] P2_Y0   = 5'd12,
  parameter dir_t           P2_DIR0 = DIR_LEFT
) (
  input logic                 dclk,
  input logic                 rst,
  light_cycle_engine_if.slave bus
);

  localparam logic [IDX_W-1:0] P1_START_IDX = cell_idx(P1_X0, P1_Y0);
  localparam logic [IDX_W-1:0] P2_START_IDX = cell_idx(P2_X0, P2_Y0);

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             step;
  logic             run;
  logic             crash_evt;
  logic [X_W:0]     p1_nx;
  logic [X_W:0]     p2_nx;
  logic [Y_W:0]     p1_ny;
  logic [Y_W:0]     p2_ny;
  logic             p1_off;
  logic             p2_off;
  logic [IDX_W-1:0] p1_idx;
  logic [IDX_W-1:0] p2_idx;
  logic [CELLS-1:0] trace_1_q;
  logic [CELLS-1:0] trace_2_q;
  logic [CELLS-1:0] occupied;
  logic             head_on;
  logic             p1_crash;
  logic             p2_crash;
  logic [1:0]       win_code;
  logic             running_q;
  logic             game_over_q;
  logic [1:0]       winner_q;

  assign run = (state == ST_RUN);

  light_cycle_engine_player #(.X0(P1_X0), .Y0(P1_Y0), .DIR0(P1_DIR0)) u_p1 (
    .dclk     (dclk),
    .rst      (rst),
    .load     (load),
    .run      (run),
    .step     (step),
    .btn      (bus.p1_btn),
    .next_x   (p1_nx),
    .next_y   (p1_ny),
    .off_grid (p1_off)
  );

  light_cycle_engine_player #(.X0(P2_X0), .Y0(P2_Y0), .DIR0(P2_DIR0)) u_p2 (
    .dclk     (dclk),
    .rst      (rst),
    .load     (load),
    .run      (run),
    .step     (step),
    .btn      (bus.p2_btn),
    .next_x   (p2_nx),
    .next_y   (p2_ny),
    .off_grid (p2_off)
  );

  // Off-grid moves may produce a meaningless index; the off flag dominates the OR.
  always_comb begin
    occupied = trace_1_q | trace_2_q;
    p1_idx   = cell_idx(p1_nx[X_W-1:0], p1_ny[Y_W-1:0]);
    p2_idx   = cell_idx(p2_nx[X_W-1:0], p2_ny[Y_W-1:0]);
    head_on  = (p1_nx == p2_nx) && (p1_ny == p2_ny);
    p1_crash = p1_off || occupied[p1_idx] || head_on;
    p2_crash = p2_off || occupied[p2_idx] || head_on;
    if (p1_crash && p2_crash) win_code = WIN_DRAW;
    else if (p2_crash)        win_code = WIN_P1;
    else                      win_code = WIN_P2;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    crash_evt  = 1'b0;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.game_tick) begin
          if (p1_crash || p2_crash) begin
            crash_evt  = 1'b1;
            state_next = ST_OVER;
          end else begin
            step = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge dclk) begin
    if (rst) begin
      state       <= ST_IDLE;
      trace_1_q   <= '0;
      trace_2_q   <= '0;
      running_q   <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= WIN_NONE;
    end else begin
      state       <= state_next;
      running_q   <= (state_next == ST_RUN);
      game_over_q <= (state_next == ST_OVER);
      if (load) begin
        trace_1_q               <= '0;
        trace_2_q               <= '0;
        trace_1_q[P1_START_IDX] <= 1'b1;
        trace_2_q[P2_START_IDX] <= 1'b1;
        winner_q                <= WIN_NONE;
      end else if (step) begin
        trace_1_q[p1_idx] <= 1'b1;
        trace_2_q[p2_idx] <= 1'b1;
      end else if (crash_evt) begin
        winner_q <= win_code;
      end
    end
  end

  assign bus.trace_1   = trace_1_q;
  assign bus.trace_2   = trace_2_q;
  assign bus.running   = running_q;
  assign bus.game_over = game_over_q;
  assign bus.winner    = winner_q;

endmodule

// File: tb/tb_light_cycle_engine.sv
// Self-checking bench for light_cycle_engine: grid-level reference model checked every
// cycle, a vector table, scripted round scenarios and a randomized phase.
module tb_light_cycle_engine;
  import light_cycle_engine_pkg::*;

  logic dclk = 1'b0;
  logic rst  = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 dclk = ~dclk;

  light_cycle_engine_if bus ();
  light_cycle_engine_if bus_h ();

  light_cycle_engine dut (
    .dclk (dclk),
    .rst  (rst),
    .bus  (bus)
  );

  // Second copy with player 2 one column closer so a head-on meeting is reachable.
  light_cycle_engine #(.P2_X0(5'd26)) dut_h (
    .dclk (dclk),
    .rst  (rst),
    .bus  (bus_h)
  );

  // Reference model: player positions as plain integers on the grid.
  int           m_mode;
  int           m_x [2];
  int           m_y [2];
  int           m_dir [2];
  int           m_pend [2];
  logic [767:0] m_trace [2];
  logic [1:0]   m_winner;
  int           start_x [2] = '{4, 27};
  int           start_y [2] = '{12, 12};
  int           start_dir [2] = '{1, 3};
  int           dx [4] = '{0, 1, 0, -1};
  int           dy [4] = '{-1, 0, 1, 0};

  typedef struct {
    logic       rst;
    logic       start;
    logic       tick;
    logic [3:0] b1;
    logic [3:0] b2;
    logic       exp_run;
    logic       exp_over;
    logic [1:0] exp_win;
    int         exp_n1;
    int         exp_n2;
  } vec_t;

  vec_t vecs [8];

  function automatic int decode_btn(input logic [3:0] b);
    if (b[3]) return 0;
    if (b[2]) return 1;
    if (b[1]) return 2;
    if (b[0]) return 3;
    return -1;
  endfunction

  task automatic model_place_players();
    for (int p = 0; p < 2; p++) begin
      m_x[p]    = start_x[p];
      m_y[p]    = start_y[p];
      m_dir[p]  = start_dir[p];
      m_pend[p] = start_dir[p];
    end
  endtask

  task automatic model_step(input logic r, input logic s, input logic t,
                            input logic [3:0] b1, input logic [3:0] b2);
    int         nx [2];
    int         ny [2];
    int         old_dir [2];
    int         req;
    bit         crash [2];
    logic [3:0] b [2];
    if (r) begin
      m_mode     = 0;
      m_trace[0] = '0;
      m_trace[1] = '0;
      m_winner   = 2'b00;
      model_place_players();
      return;
    end
    if (m_mode != 1) begin
      if (s) begin
        m_mode     = 1;
        m_winner   = 2'b00;
        m_trace[0] = '0;
        m_trace[1] = '0;
        model_place_players();
        for (int p = 0; p < 2; p++) m_trace[p][start_y[p]*32 + start_x[p]] = 1'b1;
      end
      return;
    end
    b[0] = b1;
    b[1] = b2;
    for (int p = 0; p < 2; p++) old_dir[p] = m_dir[p];
    if (t) begin
      for (int p = 0; p < 2; p++) begin
        nx[p]    = m_x[p] + dx[m_pend[p]];
        ny[p]    = m_y[p] + dy[m_pend[p]];
        crash[p] = (nx[p] < 0) || (nx[p] >= 32) || (ny[p] < 0) || (ny[p] >= 24);
        if (!crash[p] && (m_trace[0][ny[p]*32 + nx[p]] || m_trace[1][ny[p]*32 + nx[p]]))
          crash[p] = 1'b1;
      end
      if (nx[0] == nx[1] && ny[0] == ny[1]) begin
        crash[0] = 1'b1;
        crash[1] = 1'b1;
      end
      if (crash[0] || crash[1]) begin
        m_mode   = 2;
        m_winner = (crash[0] && crash[1]) ? 2'b11 : (crash[1] ? 2'b01 : 2'b10);
      end else begin
        for (int p = 0; p < 2; p++) begin
          m_x[p]   = nx[p];
          m_y[p]   = ny[p];
          m_dir[p] = m_pend[p];
          m_trace[p][ny[p]*32 + nx[p]] = 1'b1;
        end
      end
    end
    for (int p = 0; p < 2; p++) begin
      req = decode_btn(b[p]);
      if (req >= 0 && req != (old_dir[p] + 2) % 4) m_pend[p] = req;
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic check_trace(input string name, input logic [767:0] got,
                             input logic [767:0] exp);
    int first;
    checks++;
    if (got !== exp) begin
      errors++;
      first = -1;
      for (int i = 0; i < 768; i++) begin
        if (got[i] !== exp[i]) begin
          first = i;
          break;
        end
      end
      $display("[TB] FAIL %s: got %0d set bits, required %0d set bits, first differing index %0d",
               name, $countones(got), $countones(exp), first);
    end
  endtask

  task automatic checkOutput();
    check_int("running", int'(bus.running), (m_mode == 1) ? 1 : 0);
    check_int("game_over", int'(bus.game_over), (m_mode == 2) ? 1 : 0);
    check_int("winner", int'(bus.winner), int'(m_winner));
    check_trace("trace_1", bus.trace_1, m_trace[0]);
    check_trace("trace_2", bus.trace_2, m_trace[1]);
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic t,
                               input logic [3:0] b1, input logic [3:0] b2);
    rst           = r;
    bus.start     = s;
    bus.game_tick = t;
    bus.p1_btn    = b1;
    bus.p2_btn    = b2;
    @(posedge dclk);
    model_step(r, s, t, b1, b2);
    @(negedge dclk);
    checkOutput();
  endtask

  task automatic ticks(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 1'b1, 4'h0, 4'h0);
  endtask

  task automatic head_on_cycle(input logic s, input logic t);
    bus_h.start     = s;
    bus_h.game_tick = t;
    applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
    bus_h.start     = 1'b0;
    bus_h.game_tick = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [767:0] e1;
    logic [767:0] e2;
    logic         r, s, t;
    logic [3:0]   b1, b2;

    bus.start       = 1'b0;
    bus.game_tick   = 1'b0;
    bus.p1_btn      = 4'h0;
    bus.p2_btn      = 4'h0;
    bus_h.start     = 1'b0;
    bus_h.game_tick = 1'b0;
    bus_h.p1_btn    = 4'h0;
    bus_h.p2_btn    = 4'h0;

    // rst, start, tick, p1_btn, p2_btn | running, game_over, winner, |trace_1|, |trace_2|
    vecs[0] = '{1'b1, 1'b0, 1'b0, 4'h0,    4'h0, 1'b0, 1'b0, 2'b00, 0, 0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 4'h0,    4'h0, 1'b0, 1'b0, 2'b00, 0, 0};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 4'h0,    4'h0, 1'b1, 1'b0, 2'b00, 1, 1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 4'h0,    4'h0, 1'b1, 1'b0, 2'b00, 2, 2};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 4'h0,    4'h0, 1'b1, 1'b0, 2'b00, 3, 3};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 4'b0001, 4'h0, 1'b1, 1'b0, 2'b00, 3, 3};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 4'b0001, 4'h0, 1'b1, 1'b0, 2'b00, 4, 4};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 4'h0,    4'h0, 1'b0, 1'b0, 2'b00, 0, 0};

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].tick, vecs[i].b1, vecs[i].b2);
      check_int($sformatf("vec%0d running", i), int'(bus.running), int'(vecs[i].exp_run));
      check_int($sformatf("vec%0d game_over", i), int'(bus.game_over), int'(vecs[i].exp_over));
      check_int($sformatf("vec%0d winner", i), int'(bus.winner), int'(vecs[i].exp_win));
      check_int($sformatf("vec%0d trace_1 bits", i), $countones(bus.trace_1), vecs[i].exp_n1);
      check_int($sformatf("vec%0d trace_2 bits", i), $countones(bus.trace_2), vecs[i].exp_n2);
    end

    // Straight run until both riders hit the other's trail.
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    ticks(11);
    e1 = '0;
    e2 = '0;
    for (int x = 4; x <= 15; x++) e1[12*32 + x] = 1'b1;
    for (int x = 16; x <= 27; x++) e2[12*32 + x] = 1'b1;
    check_trace("straight trace_1", bus.trace_1, e1);
    check_trace("straight trace_2", bus.trace_2, e2);
    check_int("straight running", int'(bus.running), 1);
    ticks(1);
    check_int("straight winner", int'(bus.winner), 3);
    check_int("straight game_over", int'(bus.game_over), 1);
    check_trace("straight trace_1 after crash", bus.trace_1, e1);

    // Player 1 drives off the top edge.
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1000, 4'h0);
    ticks(12);
    check_int("top edge reached", int'(bus.trace_1[0*32 + 4]), 1);
    check_int("top edge trail", $countones(bus.trace_1), 13);
    ticks(1);
    check_int("off-grid winner", int'(bus.winner), 2);
    check_int("off-grid trail unchanged", $countones(bus.trace_1), 13);

    // Reversal request is dropped; then loop back into own trail.
    applyStimulus(1'b0, 1'b1, 1'b0, 4'h0, 4'h0);
    applyStimulus(1'b0, 1'b0, 0, 4'b0001, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 4'b0001, 4'h0);
    check_int("reversal x=5 set", int'(bus.trace_1[12*32 + 5]), 1);
    check_int("reversal x=3 clear", int'(bus.trace_1[12*32 + 3]), 0);
    ticks(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b1000, 4'h0);
    ticks(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0001, 4'h0);
    ticks(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 4'b0010, 4'h0);
    check_int("loop trail before crash", $countones(bus.trace_1), 5);
    ticks(1);
    check_int("loop winner", int'(bus.winner), 2);
    check_int("loop trail after crash", $countones(bus.trace_1), 5);

    // Tick in OVER is ignored; start+tick in OVER restarts cleanly.
    ticks(1);
    check_int("over tick game_over", int'(bus.game_over), 1);
    check_int("over tick winner", int'(bus.winner), 2);
    applyStimulus(1'b0, 1'b1, 1'b1, 4'h0, 4'h0);
    e1 = '0;
    e2 = '0;
    e1[12*32 + 4]  = 1'b1;
    e2[12*32 + 27] = 1'b1;
    check_int("restart running", int'(bus.running), 1);
    check_int("restart winner", int'(bus.winner), 0);
    check_trace("restart trace_1", bus.trace_1, e1);
    check_trace("restart trace_2", bus.trace_2, e2);

    // Reset landing on a tick cycle mid-round.
    ticks(3);
    applyStimulus(1'b1, 1'b0, 1'b1, 4'h0, 4'h0);
    check_trace("mid reset trace_1", bus.trace_1, '0);
    check_int("mid reset running", int'(bus.running), 0);
    check_int("mid reset winner", int'(bus.winner), 0);

    // Head-on meeting on the second instance.
    head_on_cycle(1'b1, 1'b0);
    repeat (10) head_on_cycle(1'b0, 1'b1);
    check_int("head-on running", int'(bus_h.running), 1);
    check_int("head-on trail 1", $countones(bus_h.trace_1), 11);
    check_int("head-on trail 2", $countones(bus_h.trace_2), 11);
    head_on_cycle(1'b0, 1'b1);
    check_int("head-on winner", int'(bus_h.winner), 3);
    check_int("head-on game_over", int'(bus_h.game_over), 1);
    check_int("head-on running after", int'(bus_h.running), 0);
    check_int("head-on cell 1 clear", int'(bus_h.trace_1[12*32 + 15]), 0);
    check_int("head-on cell 2 clear", int'(bus_h.trace_2[12*32 + 15]), 0);

    // Randomized play against the reference model.
    for (int i = 0; i < 1500; i++) begin
      r  = ($urandom_range(0, 299) == 0);
      s  = ($urandom_range(0, 9) == 0);
      t  = ($urandom_range(0, 2) == 0);
      b1 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      b2 = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      applyStimulus(r, s, t, b1, b2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
